hop_afh_remap: RTL and testbench

- Sequential per-slot hop-channel back end for connection state.
- Computes F = dividend mod N_CH and F' = dividend mod afh_n with a serial remainder engine that handles any divisor.
- When AFH is enabled and the unmapped channel is marked unused in the channel map, it remaps the channel to a used one with a serial map scan.
- Sits after the hopping-control-word generator; its div_en-style pulse drives start_p and its kernel output drives ch_in.

---
 rtl/hop_afh_remap_pkg.sv | 23 ++
 rtl/hop_afh_remap_seq_mod_rem.sv | 57 +++++
 rtl/hop_afh_remap.sv | 204 ++++++++++++++++++++
 tb/tb_hop_afh_remap.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hop_afh_remap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hop_pkg
//  Description : Shared types and constants for the AFH hop-channel back end.
//                Holds the sequencer state encoding and the standard
//                channel-count / minimum-used-channel constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package hop_pkg;

    localparam int N_CH_BT      = 79;
    localparam int AFH_N_MIN_BT = 20;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DIV    = 3'd1,
        REDUCE = 3'd2,
        SCAN   = 3'd3,
        DONE   = 3'd4
    } hop_state_t;

endpackage
`default_nettype wire

// File: rtl/hop_afh_remap_seq_mod_rem.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mod_rem
//  Description : Serial restoring remainder. Consumes one dividend bit per
//                enabled cycle, MSB first, and keeps a running remainder.
//                Works for any divisor, including 0 (the result is then
//                meaningless but the engine never stalls).
//  Ports       : clk_6M   - clock
//                rstz     - asynchronous active-low reset
//                start    - load dividend, clear remainder
//                en       - process one dividend bit
//                dividend - value to reduce (sampled on start)
//                divisor  - modulus, must be stable while en is high
//                rem      - running / final remainder
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mod_rem #(
    parameter int DIVW = 25,
    parameter int CHW  = 7
) (
    input  logic            clk_6M,
    input  logic            rstz,
    input  logic            start,
    input  logic            en,
    input  logic [DIVW-1:0] dividend,
    input  logic [CHW-1:0]  divisor,
    output logic [CHW-1:0]  rem
);

    logic [DIVW-1:0] shreg;
    logic [CHW:0]    r;
    logic [CHW:0]    r_shift;
    logic [CHW:0]    r_next;
    logic [CHW:0]    divisor_ext;

    assign divisor_ext = {1'b0, divisor};
    // One extra bit keeps the doubled remainder exact before the compare.
    assign r_shift     = (r << 1) | {{CHW{1'b0}}, shreg[DIVW-1]};
    assign r_next      = (r_shift >= divisor_ext) ? (r_shift - divisor_ext) : r_shift;

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            shreg <= '0;
            r     <= '0;
        end else if (start) begin
            shreg <= dividend;
            r     <= '0;
        end else if (en) begin
            shreg <= shreg << 1;
            r     <= r_next;
        end
    end

    assign rem = r[CHW-1:0];

endmodule
`default_nettype wire

// File: rtl/hop_afh_remap.sv
`default_nettype none
// ============================================================================
//  Module      : hop_afh_remap
//  Description : Per-slot hop-channel back end. Computes F = dividend mod N_CH
//                and F' = dividend mod afh_n with two serial remainder
//                engines, then, when AFH is enabled and the unmapped channel
//                is unused, remaps it to the idx-th used channel of chmap.
//  Ports       : clk_6M, rstz        - clock, async active-low reset
//                start_p, abort_p    - run start / synchronous abort
//                dividend, ch_in,
//                afh_en, afh_n, chmap - run inputs, sampled on start_p
//                busy, done_p        - run status / result-valid pulse
//                ch_out, F_o,
//                Fprime_o, err       - results, held until next done_p
//  Revision    : 1.0 - initial release
// ============================================================================
module hop_afh_remap
    import hop_pkg::*;
#(
    parameter int N_CH      = N_CH_BT,
    parameter int CHW       = 7,
    parameter int DIVW      = 25,
    parameter int AFH_N_MIN = AFH_N_MIN_BT
) (
    input  logic            clk_6M,
    input  logic            rstz,
    input  logic            start_p,
    input  logic            abort_p,
    input  logic [DIVW-1:0] dividend,
    input  logic [CHW-1:0]  ch_in,
    input  logic            afh_en,
    input  logic [CHW-1:0]  afh_n,
    input  logic [N_CH-1:0] chmap,
    output logic            busy,
    output logic            done_p,
    output logic [CHW-1:0]  ch_out,
    output logic [CHW-1:0]  F_o,
    output logic [CHW-1:0]  Fprime_o,
    output logic            err
);

    localparam int             DCW       = (DIVW > 1) ? $clog2(DIVW) : 1;
    localparam logic [DCW-1:0] DIV_LAST  = DCW'(DIVW - 1);
    localparam logic [CHW-1:0] N_CH_C    = CHW'(N_CH);
    localparam logic [CHW-1:0] AFH_MIN_C = CHW'(AFH_N_MIN);
    localparam logic [CHW-1:0] P_LAST    = CHW'(N_CH - 1);

    hop_state_t state, state_d;

    // Shadow copies of the run inputs.
    logic [CHW-1:0]  ch_s;
    logic            afh_en_s;
    logic [CHW-1:0]  afh_n_s;
    logic [N_CH-1:0] chmap_s;

    logic [DCW-1:0]  div_cnt;
    logic [CHW:0]    idx;
    logic            idx_first;
    logic [CHW-1:0]  p;
    logic [CHW-1:0]  cnt;
    logic [CHW-1:0]  res_ch;
    logic            res_err;
    logic            res_fp_ok;

    logic [CHW-1:0]  rem_f;
    logic [CHW-1:0]  rem_fp;

    logic            start_acc;
    logic            div_last;
    logic            afh_bad;
    logic            ch_used;
    logic [CHW:0]    afh_ext;
    logic [CHW:0]    idx_cur;
    logic            idx_ge;
    logic            scan_hit;
    logic            p_last;

    assign start_acc = start_p && !abort_p && (state == IDLE);
    assign div_last  = (div_cnt == DIV_LAST);
    assign afh_bad   = (afh_n_s < AFH_MIN_C) || (afh_n_s > N_CH_C);
    assign ch_used   = chmap_s[ch_s];
    assign afh_ext   = {1'b0, afh_n_s};
    // The first REDUCE cycle seeds idx straight from the finished F' engine.
    assign idx_cur   = idx_first ? ({1'b0, rem_fp} + {1'b0, ch_s}) : idx;
    assign idx_ge    = (idx_cur >= afh_ext);
    assign scan_hit  = chmap_s[p] && (cnt == idx[CHW-1:0]);
    assign p_last    = (p == P_LAST);

    seq_mod_rem #(.DIVW(DIVW), .CHW(CHW)) u_rem_f (
        .clk_6M   (clk_6M),
        .rstz     (rstz),
        .start    (start_acc),
        .en       (state == DIV),
        .dividend (dividend),
        .divisor  (N_CH_C),
        .rem      (rem_f)
    );

    seq_mod_rem #(.DIVW(DIVW), .CHW(CHW)) u_rem_fp (
        .clk_6M   (clk_6M),
        .rstz     (rstz),
        .start    (start_acc),
        .en       (state == DIV),
        .dividend (dividend),
        .divisor  (afh_n_s),
        .rem      (rem_fp)
    );

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:   if (start_p) state_d = DIV;
            DIV: begin
                if (div_last) begin
                    if (!afh_en_s || ch_used || afh_bad) state_d = DONE;
                    else                                 state_d = REDUCE;
                end
            end
            REDUCE: if (!idx_ge) state_d = SCAN;
            SCAN:   if (scan_hit || p_last) state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_p) state_d = IDLE;
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            ch_s      <= '0;
            afh_en_s  <= 1'b0;
            afh_n_s   <= '0;
            chmap_s   <= '0;
            div_cnt   <= '0;
            idx       <= '0;
            idx_first <= 1'b0;
            p         <= '0;
            cnt       <= '0;
            res_ch    <= '0;
            res_err   <= 1'b0;
            res_fp_ok <= 1'b0;
            done_p    <= 1'b0;
            ch_out    <= '0;
            F_o       <= '0;
            Fprime_o  <= '0;
            err       <= 1'b0;
        end else begin
            done_p <= 1'b0;
            if (start_acc) begin
                ch_s     <= ch_in;
                afh_en_s <= afh_en;
                afh_n_s  <= afh_n;
                chmap_s  <= chmap;
                div_cnt  <= '0;
            end
            case (state)
                DIV: begin
                    div_cnt <= div_cnt + 1'b1;
                    if (div_last) begin
                        idx_first <= 1'b1;
                        p         <= '0;
                        cnt       <= '0;
                        res_ch    <= ch_s;
                        res_err   <= afh_en_s && !ch_used && afh_bad;
                        // An out-of-range afh_n makes F' meaningless; report 0.
                        res_fp_ok <= afh_en_s && !afh_bad;
                    end
                end
                REDUCE: begin
                    idx_first <= 1'b0;
                    idx       <= idx_ge ? (idx_cur - afh_ext) : idx_cur;
                end
                SCAN: begin
                    if (scan_hit) begin
                        res_ch <= p;
                    end else begin
                        if (chmap_s[p]) cnt <= cnt + 1'b1;
                        if (p_last)     res_err <= 1'b1;
                        p <= p + 1'b1;
                    end
                end
                DONE: begin
                    if (!abort_p) begin
                        done_p   <= 1'b1;
                        ch_out   <= res_ch;
                        err      <= res_err;
                        F_o      <= rem_f;
                        Fprime_o <= res_fp_ok ? rem_fp : '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // done_p is the final cycle of a run, so it extends busy by one.
    assign busy = (state != IDLE) || done_p;

endmodule
`default_nettype wire

// File: tb/tb_hop_afh_remap.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hop_afh_remap
//  Description : Self-checking bench for hop_afh_remap. Directed and random
//                runs are compared against an arithmetic reference model of
//                the modulo / remap rules, plus control edge cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hop_afh_remap;

    logic        clk_6M = 1'b0;
    logic        rstz = 1'b0;
    logic        start_p = 1'b0;
    logic        abort_p = 1'b0;
    logic [24:0] dividend = '0;
    logic [6:0]  ch_in = '0;
    logic        afh_en = 1'b0;
    logic [6:0]  afh_n = '0;
    logic [78:0] chmap = '0;
    logic        busy;
    logic        done_p;
    logic [6:0]  ch_out;
    logic [6:0]  F_o;
    logic [6:0]  Fprime_o;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    hop_afh_remap dut (
        .clk_6M   (clk_6M),
        .rstz     (rstz),
        .start_p  (start_p),
        .abort_p  (abort_p),
        .dividend (dividend),
        .ch_in    (ch_in),
        .afh_en   (afh_en),
        .afh_n    (afh_n),
        .chmap    (chmap),
        .busy     (busy),
        .done_p   (done_p),
        .ch_out   (ch_out),
        .F_o      (F_o),
        .Fprime_o (Fprime_o),
        .err      (err)
    );

    always #5 clk_6M = ~clk_6M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: F, F', and the idx-th used channel found by counting.
    function automatic void ref_model(input logic [24:0] d, input int ch, input bit en,
                                      input int an, input logic [78:0] map,
                                      output int ech, output int ef, output int efp,
                                      output int eerr, output int elat);
        int dv, legal, idx, reds, used;
        dv   = int'(d);
        ef   = dv % 79;
        efp  = 0;
        ech  = ch;
        eerr = 0;
        elat = 27;
        legal = (an >= 20 && an <= 79) ? 1 : 0;
        if (!en) return;
        if (legal != 0) efp = dv % an;
        if (map[ch]) return;
        if (legal == 0) begin
            eerr = 1;
            return;
        end
        idx  = (efp + ch) % an;
        reds = (efp + ch) / an + 1;
        used = 0;
        for (int c = 0; c < 79; c++) begin
            if (map[c]) begin
                if (used == idx) begin
                    ech  = c;
                    elat = 27 + reds + c + 1;
                    return;
                end
                used++;
            end
        end
        eerr = 1;
        elat = 27 + reds + 79;
    endfunction

    // One complete run; a start_p is re-pulsed at cycle 'poke' (0 = never).
    task automatic run(input logic [24:0] d, input int ch, input bit en, input int an,
                       input logic [78:0] map, input int poke);
        int ech, ef, efp, eerr, elat, k;
        ref_model(d, ch, en, an, map, ech, ef, efp, eerr, elat);
        dividend = d;
        ch_in    = 7'(ch);
        afh_en   = en;
        afh_n    = 7'(an);
        chmap    = map;
        start_p  = 1'b1;
        @(negedge clk_6M);
        start_p = 1'b0;
        k = 1;
        chk("busy_after_start", 32'(busy), 32'd1);
        while (!done_p && k < 600) begin
            if (k == poke) begin
                start_p  = 1'b1;
                dividend = ~d;
                ch_in    = 7'(ch ^ 1);
                afh_en   = ~en;
            end else begin
                start_p = 1'b0;
            end
            @(negedge clk_6M);
            k++;
        end
        start_p = 1'b0;
        chk("latency",  32'(k),        32'(elat));
        chk("ch_out",   32'(ch_out),   32'(ech));
        chk("F_o",      32'(F_o),      32'(ef));
        chk("Fprime_o", 32'(Fprime_o), 32'(efp));
        chk("err",      32'(err),      32'(eerr));
        chk("busy_at_done", 32'(busy), 32'd1);
        @(negedge clk_6M);
        chk("done_pulse_width", 32'(done_p), 32'd0);
        chk("busy_after_done",  32'(busy),   32'd0);
        chk("ch_out_hold",      32'(ch_out), 32'(ech));
    endtask

    logic [78:0] m;
    int          seen;

    initial begin
        // Reset state
        repeat (3) @(negedge clk_6M);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done_p",   32'(done_p),   32'd0);
        chk("rst_err",      32'(err),      32'd0);
        chk("rst_ch_out",   32'(ch_out),   32'd0);
        chk("rst_F_o",      32'(F_o),      32'd0);
        chk("rst_Fprime_o", 32'(Fprime_o), 32'd0);
        rstz = 1'b1;
        @(negedge clk_6M);

        // Directed paths
        run(25'd1000, 12, 1'b0, 20, {79{1'b1}}, 0);                 // used path, AFH off
        run(25'd1000, 40, 1'b1, 20, {79{1'b1}}, 0);                 // full map
        m = {79{1'b1}}; m[5] = 1'b0;
        run(25'd1000, 5, 1'b1, 78, m, 0);                           // remap to 70
        m = {79{1'b1}}; m[33] = 1'b0;
        run(25'd123457, 33, 1'b1, 0, m, 0);                         // afh_n = 0
        run(25'd123457, 33, 1'b1, 100, m, 0);                       // afh_n > N_CH
        m = '0; m[9:0] = '1;
        run(25'd1000, 50, 1'b1, 20, m, 0);                          // scan exhausts
        run(25'h1FFFFFF, 78, 1'b1, 79, {1'b0, {78{1'b1}}}, 0);      // max dividend, last channel

        // start_p while busy is ignored
        m = {79{1'b1}}; m[5] = 1'b0;
        run(25'd1000, 5, 1'b1, 78, m, 10);
        run(25'd777, 12, 1'b0, 20, {79{1'b1}}, 26);

        // Randomised runs
        for (int i = 0; i < 30; i++) begin
            int an, ch;
            logic [24:0] d;
            d  = 25'($urandom);
            ch = int'($urandom_range(0, 78));
            an = int'($urandom_range(20, 79));
            if ($urandom_range(0, 1) == 1) begin
                m = {79{1'b1}};
                for (int j = 0; j < 79 - an; j++) begin
                    int c;
                    c = int'($urandom_range(0, 78));
                    while (!m[c]) c = (c + 1) % 79;
                    m[c] = 1'b0;
                end
            end else begin
                m = {15'($urandom), $urandom, $urandom};
            end
            run(d, ch, ($urandom_range(0, 3) != 0), an, m, 0);
        end

        // abort_p during SCAN: no done_p, busy drops, outputs held
        m = {79{1'b1}}; m[5] = 1'b0;
        run(25'd1000, 5, 1'b1, 78, m, 0);
        dividend = 25'd1000; ch_in = 7'd5; afh_en = 1'b1; afh_n = 7'd78; chmap = m;
        start_p = 1'b1;
        @(negedge clk_6M);
        start_p = 1'b0;
        repeat (39) @(negedge clk_6M);
        abort_p = 1'b1;
        @(negedge clk_6M);
        abort_p = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        seen = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk_6M);
            if (done_p) seen++;
        end
        chk("abort_no_done",   32'(seen),   32'd0);
        chk("abort_hold_ch",   32'(ch_out), 32'd70);
        chk("abort_hold_fp",   32'(Fprime_o), 32'd64);

        // abort_p together with start_p in IDLE: start dropped
        start_p = 1'b1;
        abort_p = 1'b1;
        @(negedge clk_6M);
        start_p = 1'b0;
        abort_p = 1'b0;
        chk("abort_start_busy", 32'(busy), 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_6M);
            if (done_p || busy) seen++;
        end
        chk("abort_start_idle", 32'(seen), 32'd0);

        // Reset mid-DIV clears everything
        run(25'd1000, 12, 1'b0, 20, {79{1'b1}}, 0);
        dividend = 25'd1000; ch_in = 7'd40; afh_en = 1'b1; afh_n = 7'd20; chmap = {79{1'b1}};
        start_p = 1'b1;
        @(negedge clk_6M);
        start_p = 1'b0;
        repeat (9) @(negedge clk_6M);
        rstz = 1'b0;
        @(negedge clk_6M);
        chk("midrst_busy",     32'(busy),     32'd0);
        chk("midrst_done_p",   32'(done_p),   32'd0);
        chk("midrst_ch_out",   32'(ch_out),   32'd0);
        chk("midrst_F_o",      32'(F_o),      32'd0);
        chk("midrst_Fprime_o", 32'(Fprime_o), 32'd0);
        chk("midrst_err",      32'(err),      32'd0);
        rstz = 1'b1;
        @(negedge clk_6M);

        // Normal run after reset still works
        run(25'd4242, 7, 1'b0, 20, {79{1'b1}}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
